// File: rtl/mac_issue_pkg.sv
// Shared definitions for the MAC issue block: op encodings, sequencer states, latency table.
package mac_issue_pkg;

  localparam logic [3:0] OP_LDS_R   = 4'b0000;
  localparam logic [3:0] OP_MUL_L   = 4'b0001;
  localparam logic [3:0] OP_DMULS_L = 4'b0010;
  localparam logic [3:0] OP_DMULU_L = 4'b0011;
  localparam logic [3:0] OP_MULS_W  = 4'b0110;
  localparam logic [3:0] OP_MULU_W  = 4'b0111;
  localparam logic [3:0] OP_LDS_M   = 4'b1000;
  localparam logic [3:0] OP_MAC_L   = 4'b1001;
  localparam logic [3:0] OP_MAC_W   = 4'b1011;
  localparam logic [3:0] OP_CLRMAC  = 4'b1111;

  localparam int CNT_W = 8;

  typedef enum logic [2:0] {
    IDLE, FETCH_A, BEAT_A, FETCH_B, BEAT_B, DONE
  } state_e;

  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_MAC_L) || (op == OP_MAC_W);
  endfunction

  function automatic logic is_long_op(input logic [3:0] op);
    return (op == OP_MUL_L) || (op == OP_DMULS_L) || (op == OP_DMULU_L);
  endfunction

  function automatic logic is_word_mul(input logic [3:0] op);
    return (op == OP_MULS_W) || (op == OP_MULU_W);
  endfunction

  // Ops that write MACH/MACL directly and so must not race an in-flight product.
  function automatic logic is_lds_clr(input logic [3:0] op);
    return (op == OP_LDS_R) || (op == OP_LDS_M) || (op == OP_CLRMAC);
  endfunction

  function automatic logic is_lat_op(input logic [3:0] op);
    return is_long_op(op) || is_word_mul(op) || is_mem_op(op);
  endfunction

  function automatic logic [CNT_W-1:0] sh2_lat(input logic [3:0] op);
    logic [CNT_W-1:0] lat;
    lat = CNT_W'(1);
    if (is_long_op(op) || op == OP_MAC_W) lat = CNT_W'(2);
    if (op == OP_MAC_L)                   lat = CNT_W'(3);
    return lat;
  endfunction

endpackage

// File: rtl/mac_lat_cnt.sv
// Result-latency down-counter and STS MACx stall generation.
// MAC_TIMING_EN selects per-op SH-2 latencies instead of the flat MUL_LAT.
module mac_lat_cnt
  import mac_issue_pkg::*;
#(
  parameter int MUL_LAT = 1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       ce_i,
  input  logic       soft_rst_ni,
  input  logic       we_i,
  input  logic       sel1_i,
  input  logic [3:0] op_i,
  input  logic       busy_i,
  input  logic       sts_req_i,
  output logic       zero_o,
  output logic       sts_stall_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d, lat;
  logic             load;

  assign load = we_i & sel1_i & is_lat_op(op_i);

`ifdef MAC_TIMING_EN
  assign lat = sh2_lat(op_i);
`else
  assign lat = CNT_W'(MUL_LAT);
`endif

  always_comb begin
    cnt_d = cnt_q;
    if (load)             cnt_d = lat;
    else if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)          cnt_q <= '0;
    else if (ce_i)        cnt_q <= soft_rst_ni ? cnt_d : '0;
  end

  assign zero_o      = (cnt_q == '0);
  assign sts_stall_o = sts_req_i & (~zero_o | busy_i);

endmodule

// File: rtl/mac_issue.sv
// CPU-side issue sequencer for the multiplier's MAC_SEL/MAC_OP/MAC_WE interface.
// Optional macro MAC_TIMING_EN (see mac_lat_cnt) enables SH-2 per-op latencies.
module mac_issue
  import mac_issue_pkg::*;
#(
  parameter int MUL_LAT = 1
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        CE_R,
  input  logic        RES_N,
  input  logic        ID_REQ,
  input  logic [3:0]  ID_OP,
  input  logic [1:0]  ID_SEL,
  input  logic        ID_S,
  input  logic [31:0] ID_RM,
  input  logic [31:0] ID_RN,
  input  logic        ID_SAME,
  output logic        ID_ACK,
  output logic [31:0] MEM_A,
  output logic        MEM_SZ,
  output logic        MEM_REQ,
  input  logic        MEM_BUSY,
  input  logic [31:0] MEM_DI,
  output logic        RN_INC,
  output logic        RM_INC,
  output logic [2:0]  INC_VAL,
  output logic [1:0]  MAC_SEL,
  output logic [3:0]  MAC_OP,
  output logic        MAC_S,
  output logic        MAC_WE,
  output logic [31:0] MAC_DI,
  output logic [31:0] MAC_A,
  input  logic        STS_REQ,
  output logic        STS_STALL
);

  state_e      state_q, state_d;
  logic [3:0]  op_q;
  logic [1:0]  sel_q;
  logic        s_q, same_q;
  logic [31:0] rm_q, rn_q, data_q;
  logic        accept, cnt_zero, long_q;
  logic [2:0]  inc;
  logic [31:0] addr_b;

  assign long_q = (op_q == OP_MAC_L);
  assign inc    = long_q ? 3'd4 : 3'd2;
  // Rm==Rn means the second operand sits right after the first, past the pending Rn increment.
  assign addr_b = same_q ? (rn_q + {29'd0, inc}) : rm_q;

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    ID_ACK  = 1'b0;
    MEM_A   = '0;
    MEM_SZ  = 1'b0;
    MEM_REQ = 1'b0;
    RN_INC  = 1'b0;
    RM_INC  = 1'b0;
    INC_VAL = '0;
    MAC_SEL = '0;
    MAC_OP  = '0;
    MAC_S   = 1'b0;
    MAC_WE  = 1'b0;
    MAC_DI  = '0;
    MAC_A   = '0;
    case (state_q)
      IDLE: begin
        if (ID_REQ && (cnt_zero || !is_lds_clr(ID_OP))) begin
          accept  = 1'b1;
          state_d = is_mem_op(ID_OP) ? FETCH_A : BEAT_A;
        end
      end
      FETCH_A: begin
        MEM_REQ = 1'b1;
        MEM_A   = rn_q;
        MEM_SZ  = long_q;
        if (!MEM_BUSY) state_d = BEAT_A;
      end
      BEAT_A: begin
        MAC_WE = 1'b1;
        MAC_OP = op_q;
        MAC_S  = s_q;
        if (is_mem_op(op_q)) begin
          MAC_SEL = 2'b01;
          MAC_DI  = data_q;
          MAC_A   = rn_q;
          RN_INC  = 1'b1;
          INC_VAL = inc;
          state_d = FETCH_B;
        end else if (is_long_op(op_q)) begin
          MAC_SEL = 2'b01;
          MAC_DI  = rn_q;
          state_d = BEAT_B;
        end else begin
          state_d = DONE;
          if (op_q == OP_CLRMAC) begin
            MAC_SEL = 2'b11;
          end else if (is_word_mul(op_q)) begin
            MAC_SEL = 2'b10;
            MAC_DI  = {rn_q[15:0], rm_q[15:0]};
          end else begin
            MAC_SEL = sel_q;
            MAC_DI  = rm_q;
          end
        end
      end
      FETCH_B: begin
        MEM_REQ = 1'b1;
        MEM_A   = addr_b;
        MEM_SZ  = long_q;
        if (!MEM_BUSY) state_d = BEAT_B;
      end
      BEAT_B: begin
        MAC_WE  = 1'b1;
        MAC_OP  = op_q;
        MAC_S   = s_q;
        MAC_SEL = 2'b10;
        MAC_DI  = rm_q;
        state_d = DONE;
        if (is_mem_op(op_q)) begin
          MAC_DI  = data_q;
          MAC_A   = addr_b;
          RM_INC  = 1'b1;
          INC_VAL = inc;
        end
      end
      DONE: begin
        ID_ACK  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)    state_q <= IDLE;
    else if (CE_R) state_q <= RES_N ? state_d : IDLE;
  end

  always_ff @(posedge CLK) begin
    if (CE_R && accept) begin
      op_q   <= ID_OP;
      sel_q  <= ID_SEL;
      s_q    <= ID_S;
      rm_q   <= ID_RM;
      rn_q   <= ID_RN;
      same_q <= ID_SAME;
    end
    if (CE_R && MEM_REQ && !MEM_BUSY) data_q <= MEM_DI;
  end

  mac_lat_cnt #(.MUL_LAT(MUL_LAT)) u_lat (
    .clk_i       (CLK),
    .rst_ni      (RST_N),
    .ce_i        (CE_R),
    .soft_rst_ni (RES_N),
    .we_i        (MAC_WE),
    .sel1_i      (MAC_SEL[1]),
    .op_i        (op_q),
    .busy_i      (state_q != IDLE),
    .sts_req_i   (STS_REQ),
    .zero_o      (cnt_zero),
    .sts_stall_o (STS_STALL)
  );

endmodule

// File: tb/tb_mac_issue.sv
// Directed bench for mac_issue, built with MUL_LAT=3 so the latency gate is observable.
module tb_mac_issue;

  logic        CLK = 1'b0, RST_N = 1'b0, CE_R = 1'b1, RES_N = 1'b1;
  logic        ID_REQ = 1'b0, ID_S = 1'b0, ID_SAME = 1'b0;
  logic [3:0]  ID_OP = '0;
  logic [1:0]  ID_SEL = '0;
  logic [31:0] ID_RM = '0, ID_RN = '0, MEM_DI = '0;
  logic        MEM_BUSY = 1'b0, STS_REQ = 1'b0;
  logic        ID_ACK, MEM_SZ, MEM_REQ, RN_INC, RM_INC, MAC_S, MAC_WE, STS_STALL;
  logic [31:0] MEM_A, MAC_DI, MAC_A;
  logic [2:0]  INC_VAL;
  logic [1:0]  MAC_SEL;
  logic [3:0]  MAC_OP;
  int n_tests = 0, n_fail = 0;

  mac_issue #(.MUL_LAT(3)) dut (
    .CLK(CLK), .RST_N(RST_N), .CE_R(CE_R), .RES_N(RES_N),
    .ID_REQ(ID_REQ), .ID_OP(ID_OP), .ID_SEL(ID_SEL), .ID_S(ID_S),
    .ID_RM(ID_RM), .ID_RN(ID_RN), .ID_SAME(ID_SAME), .ID_ACK(ID_ACK),
    .MEM_A(MEM_A), .MEM_SZ(MEM_SZ), .MEM_REQ(MEM_REQ), .MEM_BUSY(MEM_BUSY),
    .MEM_DI(MEM_DI), .RN_INC(RN_INC), .RM_INC(RM_INC), .INC_VAL(INC_VAL),
    .MAC_SEL(MAC_SEL), .MAC_OP(MAC_OP), .MAC_S(MAC_S), .MAC_WE(MAC_WE),
    .MAC_DI(MAC_DI), .MAC_A(MAC_A), .STS_REQ(STS_REQ), .STS_STALL(STS_STALL)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    STS_REQ = 1'b1;
    #12;
    n_tests++; if (MAC_WE !== 1'b0) begin n_fail++; $display("FAIL rst_we got %h exp 0", MAC_WE); end
    n_tests++; if (ID_ACK !== 1'b0) begin n_fail++; $display("FAIL rst_ack got %h exp 0", ID_ACK); end
    n_tests++; if (MEM_REQ !== 1'b0) begin n_fail++; $display("FAIL rst_memreq got %h exp 0", MEM_REQ); end
    n_tests++; if (MAC_DI !== 32'h0) begin n_fail++; $display("FAIL rst_di got %h exp 0", MAC_DI); end
    n_tests++; if (STS_STALL !== 1'b0) begin n_fail++; $display("FAIL rst_stall got %h exp 0", STS_STALL); end
    STS_REQ = 1'b0;
    step();
    RST_N = 1'b1;
    step();
  endtask

  task automatic test_mulw();
    ID_OP = 4'b0110; ID_RM = 32'h0000FFFE; ID_RN = 32'h00000003; ID_S = 1'b1; ID_REQ = 1'b1;
    step();
    n_tests++; if (MAC_WE !== 1'b1) begin n_fail++; $display("FAIL mulw_we got %h exp 1", MAC_WE); end
    n_tests++; if (MAC_SEL !== 2'b10) begin n_fail++; $display("FAIL mulw_sel got %h exp 2", MAC_SEL); end
    n_tests++; if (MAC_DI !== 32'h0003FFFE) begin n_fail++; $display("FAIL mulw_di got %h exp 0003fffe", MAC_DI); end
    n_tests++; if (MAC_OP !== 4'b0110 || MAC_S !== 1'b1) begin n_fail++; $display("FAIL mulw_op got %h/%h exp 6/1", MAC_OP, MAC_S); end
    n_tests++; if (ID_ACK !== 1'b0) begin n_fail++; $display("FAIL mulw_early_ack got %h exp 0", ID_ACK); end
    step();
    n_tests++; if (ID_ACK !== 1'b1 || MAC_WE !== 1'b0) begin n_fail++; $display("FAIL mulw_ack got ack=%h we=%h exp 1/0", ID_ACK, MAC_WE); end
    ID_REQ = 1'b0; ID_S = 1'b0;
    step();
    n_tests++; if (ID_ACK !== 1'b0) begin n_fail++; $display("FAIL mulw_ack_pulse got %h exp 0", ID_ACK); end
    repeat (4) step();
  endtask

  task automatic test_dmul_stall();
    ID_OP = 4'b0010; ID_RN = 32'h80000000; ID_RM = 32'h2; STS_REQ = 1'b1; ID_REQ = 1'b1;
    #1;
    n_tests++; if (STS_STALL !== 1'b0) begin n_fail++; $display("FAIL dmul_idle_stall got %h exp 0", STS_STALL); end
    step();
    n_tests++; if (MAC_WE !== 1'b1 || MAC_SEL !== 2'b01 || MAC_DI !== 32'h80000000) begin n_fail++; $display("FAIL dmul_beat_a got we=%h sel=%h di=%h exp 1/1/80000000", MAC_WE, MAC_SEL, MAC_DI); end
    n_tests++; if (STS_STALL !== 1'b1) begin n_fail++; $display("FAIL dmul_stall_a got %h exp 1", STS_STALL); end
    step();
    n_tests++; if (MAC_WE !== 1'b1 || MAC_SEL !== 2'b10 || MAC_DI !== 32'h2) begin n_fail++; $display("FAIL dmul_beat_b got we=%h sel=%h di=%h exp 1/2/2", MAC_WE, MAC_SEL, MAC_DI); end
    step();
    n_tests++; if (ID_ACK !== 1'b1) begin n_fail++; $display("FAIL dmul_ack got %h exp 1", ID_ACK); end
    ID_REQ = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_tests++; if (STS_STALL !== 1'b1) begin n_fail++; $display("FAIL dmul_stall_hold%0d got %h exp 1", i, STS_STALL); end
      step();
    end
    n_tests++; if (STS_STALL !== 1'b0) begin n_fail++; $display("FAIL dmul_stall_release got %h exp 0", STS_STALL); end
    STS_REQ = 1'b0;
    step();
  endtask

  task automatic test_lds_gate();
    ID_OP = 4'b0011; ID_RN = 32'h5; ID_RM = 32'h7; ID_REQ = 1'b1;
    step(); step(); step();
    n_tests++; if (ID_ACK !== 1'b1) begin n_fail++; $display("FAIL gate_dmulu_ack got %h exp 1", ID_ACK); end
    ID_OP = 4'b0000; ID_SEL = 2'b01; ID_RM = 32'hCAFEBABE;
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++; if (MAC_WE !== 1'b0 || ID_ACK !== 1'b0) begin n_fail++; $display("FAIL gate_hold%0d got we=%h ack=%h exp 0/0", i, MAC_WE, ID_ACK); end
    end
    step();
    n_tests++; if (MAC_WE !== 1'b1 || MAC_SEL !== 2'b01 || MAC_DI !== 32'hCAFEBABE) begin n_fail++; $display("FAIL gate_lds_beat got we=%h sel=%h di=%h exp 1/1/cafebabe", MAC_WE, MAC_SEL, MAC_DI); end
    step();
    n_tests++; if (ID_ACK !== 1'b1) begin n_fail++; $display("FAIL gate_lds_ack got %h exp 1", ID_ACK); end
    ID_REQ = 1'b0;
    step();
  endtask

  task automatic test_macw();
    MEM_BUSY = 1'b1; ID_OP = 4'b1011; ID_RN = 32'h1002; ID_RM = 32'h2000; ID_SAME = 1'b0; ID_REQ = 1'b1;
    step();
    n_tests++; if (MEM_REQ !== 1'b1 || MEM_A !== 32'h1002 || MEM_SZ !== 1'b0) begin n_fail++; $display("FAIL macw_fetch_a got req=%h a=%h sz=%h exp 1/1002/0", MEM_REQ, MEM_A, MEM_SZ); end
    step(); step(); step();
    n_tests++; if (MEM_REQ !== 1'b1 || MAC_WE !== 1'b0) begin n_fail++; $display("FAIL macw_busy_hold got req=%h we=%h exp 1/0", MEM_REQ, MAC_WE); end
    MEM_BUSY = 1'b0; MEM_DI = 32'h1111AAAA;
    step();
    MEM_BUSY = 1'b1; MEM_DI = '0;
    n_tests++; if (MAC_WE !== 1'b1 || MAC_SEL !== 2'b01 || MAC_DI !== 32'h1111AAAA || MAC_A !== 32'h1002) begin n_fail++; $display("FAIL macw_beat_a got we=%h sel=%h di=%h a=%h", MAC_WE, MAC_SEL, MAC_DI, MAC_A); end
    n_tests++; if (RN_INC !== 1'b1 || RM_INC !== 1'b0 || INC_VAL !== 3'd2) begin n_fail++; $display("FAIL macw_rn_inc got rn=%h rm=%h val=%0d exp 1/0/2", RN_INC, RM_INC, INC_VAL); end
    step();
    n_tests++; if (MEM_REQ !== 1'b1 || MEM_A !== 32'h2000 || MEM_SZ !== 1'b0 || RN_INC !== 1'b0) begin n_fail++; $display("FAIL macw_fetch_b got req=%h a=%h sz=%h inc=%h", MEM_REQ, MEM_A, MEM_SZ, RN_INC); end
    step(); step();
    MEM_BUSY = 1'b0; MEM_DI = 32'h2222BBBB;
    step();
    MEM_BUSY = 1'b1;
    n_tests++; if (MAC_WE !== 1'b1 || MAC_SEL !== 2'b10 || MAC_DI !== 32'h2222BBBB || MAC_A !== 32'h2000) begin n_fail++; $display("FAIL macw_beat_b got we=%h sel=%h di=%h a=%h", MAC_WE, MAC_SEL, MAC_DI, MAC_A); end
    n_tests++; if (RM_INC !== 1'b1 || RN_INC !== 1'b0 || INC_VAL !== 3'd2) begin n_fail++; $display("FAIL macw_rm_inc got rm=%h rn=%h val=%0d exp 1/0/2", RM_INC, RN_INC, INC_VAL); end
    step();
    n_tests++; if (ID_ACK !== 1'b1) begin n_fail++; $display("FAIL macw_ack got %h exp 1", ID_ACK); end
    ID_REQ = 1'b0; MEM_BUSY = 1'b0;
    repeat (4) step();
  endtask

  task automatic test_macl_same();
    ID_OP = 4'b1001; ID_RN = 32'h4000; ID_RM = 32'h9990; ID_SAME = 1'b1; MEM_DI = 32'h0BADF00D; ID_REQ = 1'b1;
    step();
    n_tests++; if (MEM_A !== 32'h4000 || MEM_SZ !== 1'b1) begin n_fail++; $display("FAIL macl_fetch_a got a=%h sz=%h exp 4000/1", MEM_A, MEM_SZ); end
    step();
    n_tests++; if (RN_INC !== 1'b1 || INC_VAL !== 3'd4 || MAC_DI !== 32'h0BADF00D) begin n_fail++; $display("FAIL macl_beat_a got inc=%h val=%0d di=%h", RN_INC, INC_VAL, MAC_DI); end
    step();
    n_tests++; if (MEM_A !== 32'h4004 || MEM_SZ !== 1'b1 || MEM_REQ !== 1'b1) begin n_fail++; $display("FAIL macl_fetch_b got a=%h sz=%h req=%h exp 4004/1/1", MEM_A, MEM_SZ, MEM_REQ); end
    step();
    n_tests++; if (RM_INC !== 1'b1 || INC_VAL !== 3'd4 || MAC_A !== 32'h4004) begin n_fail++; $display("FAIL macl_beat_b got inc=%h val=%0d a=%h", RM_INC, INC_VAL, MAC_A); end
    step();
    n_tests++; if (ID_ACK !== 1'b1) begin n_fail++; $display("FAIL macl_ack got %h exp 1", ID_ACK); end
    ID_REQ = 1'b0; ID_SAME = 1'b0;
    repeat (4) step();
  endtask

  task automatic test_reset_mid_fetch();
    ID_OP = 4'b1011; ID_RN = 32'h100; ID_RM = 32'h200; MEM_BUSY = 1'b0; ID_REQ = 1'b1;
    step(); step();
    MEM_BUSY = 1'b1;
    step();
    n_tests++; if (MEM_REQ !== 1'b1 || MEM_A !== 32'h200) begin n_fail++; $display("FAIL rmf_fetch_b got req=%h a=%h exp 1/200", MEM_REQ, MEM_A); end
    #2 RST_N = 1'b0;
    #1;
    n_tests++; if (MEM_REQ !== 1'b0) begin n_fail++; $display("FAIL rmf_memreq got %h exp 0", MEM_REQ); end
    ID_REQ = 1'b0; MEM_BUSY = 1'b0;
    step();
    RST_N = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      n_tests++; if (MAC_WE !== 1'b0 || RM_INC !== 1'b0 || MEM_REQ !== 1'b0) begin n_fail++; $display("FAIL rmf_quiet%0d got we=%h rminc=%h req=%h exp 0/0/0", i, MAC_WE, RM_INC, MEM_REQ); end
    end
  endtask

  task automatic test_ce_soft_reset();
    ID_OP = 4'b0111; ID_RM = 32'h1; ID_RN = 32'h2; ID_REQ = 1'b1; CE_R = 1'b0;
    step(); step();
    n_tests++; if (MAC_WE !== 1'b0) begin n_fail++; $display("FAIL ce_idle_hold got %h exp 0", MAC_WE); end
    CE_R = 1'b1;
    step();
    CE_R = 1'b0;
    step(); step();
    n_tests++; if (MAC_WE !== 1'b1 || MAC_DI !== 32'h00020001) begin n_fail++; $display("FAIL ce_beat_hold got we=%h di=%h exp 1/00020001", MAC_WE, MAC_DI); end
    CE_R = 1'b1; RES_N = 1'b0;
    step();
    n_tests++; if (MAC_WE !== 1'b0 || ID_ACK !== 1'b0) begin n_fail++; $display("FAIL soft_rst got we=%h ack=%h exp 0/0", MAC_WE, ID_ACK); end
    ID_REQ = 1'b0; RES_N = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_mulw();
    test_dmul_stall();
    test_lds_gate();
    test_macw();
    test_macl_same();
    test_reset_mid_fetch();
    test_ce_soft_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_issue.md
Name: mac_issue

Overview:
- CPU-side initiator for the multiply/accumulate unit's MAC_SEL/MAC_OP/MAC_WE write interface.
- Accepts decoded multiply-class instructions from the ID stage.
- Fetches MAC.L/MAC.W memory operands over the data bus.
- Issues operand beats to the multiplier and stalls STS MACH/MACL reads until the pending result has been written.

Parameters:
- MUL_LAT, 1, CE_R cycles from final operand beat until MACH/MACL hold the result.

Ports:
- CLK  in  1  system clock
- RST_N  in  1  asynchronous reset, active-low
- CE_R  in  1  rising-phase clock enable; all state changes occur only when CE_R=1
- RES_N  in  1  synchronous soft reset (same effect as RST_N, sampled on CE_R)
- ID_REQ  in  1  instruction request, held until ID_ACK
- ID_OP  in  4  MAC op code, same encoding as multiplier MAC_OP
- ID_SEL  in  2  LDS target: 01=MACL, 10=MACH
- ID_S  in  1  SR.S saturation bit
- ID_RM  in  32  Rm value
- ID_RN  in  32  Rn value
- ID_SAME  in  1  Rm and Rn are the same register
- ID_ACK  out  1  one-CE_R pulse when the instruction is fully issued
- MEM_A  out  32  operand fetch address
- MEM_SZ  out  1  0=word, 1=long
- MEM_REQ  out  1  fetch request
- MEM_BUSY  in  1  fetch not complete
- MEM_DI  in  32  fetched long word
- RN_INC  out  1  post-increment Rn pulse
- RM_INC  out  1  post-increment Rm pulse
- INC_VAL  out  3  increment amount, 2 or 4
- MAC_SEL  out  2  multiplier select
- MAC_OP  out  4  multiplier op
- MAC_S  out  1  saturation
- MAC_WE  out  1  multiplier write strobe
- MAC_DI  out  32  multiplier data
- MAC_A  out  32  address forwarded for MAC.W half-word select
- STS_REQ  in  1  STS MACx read pending in the pipeline
- STS_STALL  out  1  hold the pipeline

Behaviour:
- Reset: state=IDLE; all outputs 0; latency counter 0.
- States: IDLE, FETCH_A, BEAT_A, FETCH_B, BEAT_B, DONE.
- Register-operand ops issue from IDLE in one beat: MAC_WE=1 for exactly one CE_R, then DONE. Beat contents per op:
  - LDS reg/mem (0000/1000): SEL=ID_SEL, DI=ID_RM.
  - CLRMAC (1111): SEL=11, DI=0.
  - MULx.W (0110/0111): SEL=10, DI={ID_RN[15:0],ID_RM[15:0]}.
- MUL.L/DMULx.L (0001/0010/0011): two beats, no fetch. BEAT_A: SEL=01, DI=ID_RN. BEAT_B: SEL=10, DI=ID_RM.
- MAC.L (1001) / MAC.W (1011): fetch before each beat.
  - FETCH_A: MEM_A=ID_RN, MEM_SZ=(op==1001). MEM_REQ stays high while MEM_BUSY=1.
  - When MEM_BUSY drops, go to BEAT_A: DI=MEM_DI, MAC_A=fetch address, SEL=01. RN_INC pulses with INC_VAL=4 (long) or 2 (word).
  - FETCH_B / BEAT_B do the same with ID_RM and SEL=10; RM_INC pulses.
  - If ID_SAME=1, the second fetch address is ID_RN+INC_VAL.
- MAC_OP and MAC_S are driven from the latched instruction for every beat.
- DONE: ID_ACK=1 for one CE_R, then IDLE.
- Latency: the counter loads MUL_LAT on any SEL[1] beat of ops 0001/0010/0011/0110/0111/1001/1011 and decrements each CE_R.
- STS_STALL = STS_REQ & (counter!=0 | state!=IDLE).
- A new ID_REQ is accepted only in IDLE, and only when the counter is 0 or the op is not LDS/CLRMAC. This prevents an LDS from overwriting an in-flight result.
- MEM_BUSY held high: stay in the FETCH state indefinitely.
- Reset mid-fetch: drop MEM_REQ immediately and discard the fetched data. No MAC_WE or INC pulse is emitted afterwards.

Optional Feature:
- Macro: MAC_TIMING_EN.
- Defined: the counter loads cycle-accurate SH-2 latencies instead of MUL_LAT:
  - MULx.W: 1
  - MUL.L/DMULx.L: 2
  - MAC.W: 2
  - MAC.L: 3
- Undefined: every op uses MUL_LAT.

Decomposition:
- Shared package: MAC_OP encodings as named constants, the state enum, and the latency table.
- One sub-module, mac_lat_cnt: latency down-counter plus STS_STALL generation.

Test Plan:
- MULS.W, Rm=0x0000FFFE, Rn=0x00000003 -> one beat, SEL=10, DI=0x0003FFFE; ID_ACK on the next CE_R.
- DMULS.L, Rn=0x80000000, Rm=2 -> beats SEL=01 DI=0x80000000, then SEL=10 DI=0x00000002. STS_REQ asserted immediately -> STS_STALL held MUL_LAT cycles after the second beat.
- MAC.W, Rn=0x1002, Rm=0x2000, MEM_BUSY held 3 cycles per fetch:
  - MEM_A=0x1002 then 0x2000, MEM_SZ=0.
  - MAC_A=0x1002 on beat A; RN_INC then RM_INC, each with INC_VAL=2.
- MAC.L with ID_SAME=1, Rn=0x4000 -> fetches at 0x4000 and 0x4004; two INC pulses with INC_VAL=4.
- LDS Rm,MACL requested one cycle after the DMULU.L final beat -> ID_ACK withheld until the counter reaches 0, then one beat SEL=01.
- RST_N low during FETCH_B -> MEM_REQ=0 and state IDLE; no MAC_WE or RM_INC afterwards.
